led_stack_param: RTL and testbench

//  Parametrised "stacking light" pattern generator for a WIDTH-bit LED bar.
//  A single dot enters at the far end and walks one position per step until
//  it lands on the stack; the bar then fills, holds, and empties.

---
 rtl/led_stack_param.sv | 134 +++++++++++++
 tb/tb_led_stack_param.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_stack_param.sv
// Stacking-light pattern generator for a WIDTH-bit LED bar.
// A dot walks toward the stack, lands on it, the bar fills, holds, then clears or drains.
//
// state    | meaning
// FILL     | dot walking toward the stack; lands and grows the stack by one
// FULL     | all LEDs lit, counting HOLD_TICKS step ticks
// DRAIN    | stack shrinks by one LED per step tick
module led_stack_param #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE   = 1,
    parameter int HOLD_TICKS = 2
) (
    input  logic                       clk,
    input  logic                       rs,
    input  logic                       run,
    input  logic                       dir,
    input  logic                       mode,
    output logic [WIDTH-1:0]           led,
    output logic [$clog2(WIDTH+1)-1:0] level,
    output logic                       step,
    output logic                       pass_done
);
    localparam int KW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(WIDTH);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_FULL,
        ST_DRAIN
    } state_t;

    state_t           st, st_n;
    logic [WIDTH-1:0] z, z_n;
    logic [KW-1:0]    k, k_n;
    logic [PW-1:0]    p, p_n;
    logic [HW-1:0]    h, h_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             dir_r;
    logic             tick;
    logic             end_pass;
    logic             pass_start;
    logic [WIDTH-1:0] img, img_rev;

    assign tick       = run && (cnt == CW'(PRESCALE - 1));
    assign pass_start = (st == ST_FILL) && (k == '0) && (p == PW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rs) begin
            st        <= ST_FILL;
            z         <= '0;
            k         <= '0;
            p         <= PW'(WIDTH - 1);
            h         <= '0;
            cnt       <= '0;
            dir_r     <= 1'b0;
            step      <= 1'b0;
            pass_done <= 1'b0;
        end else begin
            st        <= st_n;
            z         <= z_n;
            k         <= k_n;
            p         <= p_n;
            h         <= h_n;
            cnt       <= cnt_n;
            step      <= tick;
            pass_done <= end_pass;
            // direction is latched only while idling at the start of a pass
            if (pass_start) dir_r <= dir;
        end
    end

    always_comb begin
        st_n     = st;
        z_n      = z;
        k_n      = k;
        p_n      = p;
        h_n      = h;
        cnt_n    = cnt;
        end_pass = 1'b0;
        if (run) cnt_n = tick ? '0 : cnt + CW'(1);
        if (tick) begin
            case (st)
                ST_FILL: begin
                    if (KW'(p) > k) begin
                        p_n = p - PW'(1);
                    end else begin
                        z_n = z | (WIDTH'(1) << k);
                        k_n = k + KW'(1);
                        if (k == KW'(WIDTH - 1)) begin
                            st_n = ST_FULL;
                            h_n  = '0;
                        end else begin
                            p_n = PW'(WIDTH - 1);
                        end
                    end
                end
                ST_FULL: begin
                    h_n = h + HW'(1);
                    if (h == HW'(HOLD_TICKS - 1)) begin
                        if (mode) begin
                            st_n = ST_DRAIN;
                        end else begin
                            st_n     = ST_FILL;
                            z_n      = '0;
                            k_n      = '0;
                            p_n      = PW'(WIDTH - 1);
                            end_pass = 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    z_n = z & ~(WIDTH'(1) << (k - KW'(1)));
                    k_n = k - KW'(1);
                    if (k == KW'(1)) begin
                        st_n     = ST_FILL;
                        p_n      = PW'(WIDTH - 1);
                        end_pass = 1'b1;
                    end
                end
                default: st_n = ST_FILL;
            endcase
        end
    end

    always_comb begin
        img     = (st == ST_FILL) ? (z | (WIDTH'(1) << p)) : z;
        img_rev = '0;
        for (int i = 0; i < WIDTH; i++) img_rev[i] = img[WIDTH-1-i];
        led   = dir_r ? img_rev : img;
        level = k;
    end
endmodule

// File: tb/tb_led_stack_param.sv
// Bench for led_stack_param: directed vector table, prescaler pause sequence,
// and randomized run/dir/mode/reset checked against a pass-timeline model.
module tb_led_stack_param;
    localparam int W      = 4;
    localparam int HOLD   = 2;
    localparam int FILL_T = W * (W + 1) / 2;

    logic       clk = 1'b0;
    logic       rs = 1'b1, run = 1'b0, dir = 1'b0, mode = 1'b0;
    logic [3:0] led1, led3;
    logic [2:0] level1, level3;
    logic       step1, step3, pd1, pd3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led_stack_param #(.WIDTH(W), .PRESCALE(1), .HOLD_TICKS(HOLD)) u1 (
        .clk(clk), .rs(rs), .run(run), .dir(dir), .mode(mode),
        .led(led1), .level(level1), .step(step1), .pass_done(pd1));

    led_stack_param #(.WIDTH(W), .PRESCALE(3), .HOLD_TICKS(HOLD)) u3 (
        .clk(clk), .rs(rs), .run(run), .dir(dir), .mode(mode),
        .led(led3), .level(level3), .step(step3), .pass_done(pd3));

    // Model: a pass is a timeline of t ticks (fill then hold), optionally followed by a drain.
    typedef struct {
        int t;
        bit drain;
        int dk;
        int cnt;
        bit dir_r;
        bit step;
        bit pd;
    } ms_t;

    ms_t m1, m3;

    function automatic ms_t mstep(ms_t s, int ps, bit r, bit rn, bit d, bit md);
        ms_t n;
        bit  tk;
        n = s;
        if (r) begin
            n = '{t: 0, drain: 0, dk: 0, cnt: 0, dir_r: 0, step: 0, pd: 0};
            return n;
        end
        tk = rn && (s.cnt == ps - 1);
        if (rn) n.cnt = tk ? 0 : s.cnt + 1;
        if (!s.drain && s.t == 0) n.dir_r = d;
        n.step = tk;
        n.pd   = 1'b0;
        if (tk) begin
            if (s.drain) begin
                n.dk = s.dk - 1;
                if (n.dk == 0) begin
                    n.drain = 1'b0;
                    n.t     = 0;
                    n.pd    = 1'b1;
                end
            end else if (s.t + 1 == FILL_T + HOLD) begin
                if (md) begin
                    n.drain = 1'b1;
                    n.dk    = W;
                end else begin
                    n.t  = 0;
                    n.pd = 1'b1;
                end
            end else begin
                n.t = s.t + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] mout(ms_t s);
        int         k, rem, p;
        logic [3:0] img, rv;
        k = 0;
        p = -1;
        if (s.drain) k = s.dk;
        else if (s.t >= FILL_T) k = W;
        else begin
            rem = s.t;
            while (rem >= W - k) begin
                rem = rem - (W - k);
                k++;
            end
            p = W - 1 - rem;
        end
        img = 4'((1 << k) - 1);
        if (p >= 0) img = img | 4'(1 << p);
        for (int i = 0; i < W; i++) rv[i] = img[W-1-i];
        return {1'b0, 3'(k), (s.dir_r ? rv : img)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        m1 = mstep(m1, 1, rs, run, dir, mode);
        m3 = mstep(m3, 3, rs, run, dir, mode);
        #1;
    endtask

    task automatic chk_model();
        logic [7:0] e1, e3;
        e1 = mout(m1);
        e3 = mout(m3);
        chk("rnd_led1", 32'(led1), 32'(e1[3:0]));
        chk("rnd_level1", 32'(level1), 32'(e1[6:4]));
        chk("rnd_step1", 32'(step1), 32'(m1.step));
        chk("rnd_pd1", 32'(pd1), 32'(m1.pd));
        chk("rnd_led3", 32'(led3), 32'(e3[3:0]));
        chk("rnd_level3", 32'(level3), 32'(e3[6:4]));
        chk("rnd_step3", 32'(step3), 32'(m3.step));
        chk("rnd_pd3", 32'(pd3), 32'(m3.pd));
    endtask

    typedef struct {
        bit         rs, run, dir, mode;
        logic [3:0] led;
        logic [2:0] lvl;
        bit         step, pd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit rn, input bit d, input bit md,
                       input logic [3:0] l, input logic [2:0] lv, input bit s, input bit pdx);
        vec_t v;
        v = '{rs: r, run: rn, dir: d, mode: md, led: l, lvl: lv, step: s, pd: pdx};
        tbl.push_back(v);
    endtask

    initial begin
        // fill then clear (mode 0, dir 0), pattern restarts
        add(1, 0, 0, 0, 4'b1000, 0, 0, 0);
        add(0, 1, 0, 0, 4'b0100, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0010, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0001, 0, 1, 0);
        add(0, 1, 0, 0, 4'b1001, 1, 1, 0);
        add(0, 1, 0, 0, 4'b0101, 1, 1, 0);
        add(0, 1, 0, 0, 4'b0011, 1, 1, 0);
        add(0, 1, 0, 0, 4'b1011, 2, 1, 0);
        add(0, 1, 0, 0, 4'b0111, 2, 1, 0);
        add(0, 1, 0, 0, 4'b1111, 3, 1, 0);
        add(0, 1, 0, 0, 4'b1111, 4, 1, 0);
        add(0, 1, 0, 0, 4'b1111, 4, 1, 0);
        add(0, 1, 0, 0, 4'b1000, 0, 1, 1);
        add(0, 1, 0, 0, 4'b0100, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0010, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0001, 0, 1, 0);
        add(0, 1, 0, 0, 4'b1001, 1, 1, 0);
        // reset together with a tick wins
        add(1, 1, 0, 0, 4'b1000, 0, 0, 0);
        // mirrored pass; dir toggled mid-pass has no effect; run=0 freezes
        add(0, 1, 1, 0, 4'b0010, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0100, 0, 1, 0);
        add(0, 1, 0, 0, 4'b1000, 0, 1, 0);
        add(0, 1, 0, 0, 4'b1001, 1, 1, 0);
        add(0, 1, 0, 0, 4'b1010, 1, 1, 0);
        add(0, 0, 0, 0, 4'b1010, 1, 0, 0);
        add(1, 0, 0, 1, 4'b1000, 0, 0, 0);
        // drain mode
        add(0, 1, 0, 1, 4'b0100, 0, 1, 0);
        add(0, 1, 0, 1, 4'b0010, 0, 1, 0);
        add(0, 1, 0, 1, 4'b0001, 0, 1, 0);
        add(0, 1, 0, 1, 4'b1001, 1, 1, 0);
        add(0, 1, 0, 1, 4'b0101, 1, 1, 0);
        add(0, 1, 0, 1, 4'b0011, 1, 1, 0);
        add(0, 1, 0, 1, 4'b1011, 2, 1, 0);
        add(0, 1, 0, 1, 4'b0111, 2, 1, 0);
        add(0, 1, 0, 1, 4'b1111, 3, 1, 0);
        add(0, 1, 0, 1, 4'b1111, 4, 1, 0);
        add(0, 1, 0, 1, 4'b1111, 4, 1, 0);
        add(0, 1, 0, 1, 4'b1111, 4, 1, 0);
        add(0, 1, 0, 1, 4'b0111, 3, 1, 0);
        add(0, 1, 0, 1, 4'b0011, 2, 1, 0);
        add(0, 1, 0, 1, 4'b0001, 1, 1, 0);
        add(0, 1, 0, 1, 4'b1000, 0, 1, 1);
        add(0, 1, 0, 1, 4'b0100, 0, 1, 0);

        foreach (tbl[i]) begin
            rs   = tbl[i].rs;
            run  = tbl[i].run;
            dir  = tbl[i].dir;
            mode = tbl[i].mode;
            cyc();
            chk($sformatf("tbl%0d_led", i), 32'(led1), 32'(tbl[i].led));
            chk($sformatf("tbl%0d_level", i), 32'(level1), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_step", i), 32'(step1), 32'(tbl[i].step));
            chk($sformatf("tbl%0d_pd", i), 32'(pd1), 32'(tbl[i].pd));
        end

        // prescaler of 3 with a 5-cycle pause mid-count
        rs = 1; run = 0; dir = 0; mode = 0;
        cyc();
        rs = 0; run = 1;
        cyc();
        chk("ps_c1_step", 32'(step3), 32'd0);
        chk("ps_c1_led", 32'(led3), 32'b1000);
        cyc();
        chk("ps_c2_step", 32'(step3), 32'd0);
        cyc();
        chk("ps_c3_step", 32'(step3), 32'd1);
        chk("ps_c3_led", 32'(led3), 32'b0100);
        cyc();
        chk("ps_c4_step", 32'(step3), 32'd0);
        run = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("ps_pause_led", 32'(led3), 32'b0100);
            chk("ps_pause_level", 32'(level3), 32'd0);
            chk("ps_pause_step", 32'(step3), 32'd0);
        end
        run = 1;
        cyc();
        chk("ps_resume1_step", 32'(step3), 32'd0);
        chk("ps_resume1_led", 32'(led3), 32'b0100);
        cyc();
        chk("ps_resume2_step", 32'(step3), 32'd1);
        chk("ps_resume2_led", 32'(led3), 32'b0010);

        // randomized stimulus against the model
        rs = 1;
        cyc();
        chk_model();
        for (int i = 0; i < 4000; i++) begin
            rs   = ($urandom_range(0, 149) == 0);
            run  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) dir = ~dir;
            if ($urandom_range(0, 4) == 0) mode = ~mode;
            cyc();
            chk_model();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
